// File: rtl/sar_search.sv
// Successive-approximation search controller driving an external comparator.
// One trial bit is resolved per SEARCH cycle, MSB first, with early exit on equality.
module sar_search #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cmp_l,
    input  logic         cmp_e,
    input  logic         cmp_g,
    output logic [N-1:0] guess,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         exact,
    output logic         err
);

    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [N-1:0]    guess_q, guess_d;
    logic [N-1:0]    result_q, result_d;
    logic            exact_q, exact_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N-1:0]    next_val;
    logic [KW-1:0]   k_dec;

    assign k_dec = k_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        guess_d  = guess_q;
        result_d = result_q;
        exact_d  = exact_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        next_val = guess_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d          = StSearch;
                    k_d              = KW'(N - 1);
                    guess_d          = '0;
                    guess_d[N-1]     = 1'b1;
                    exact_d          = 1'b0;
                    err_d            = 1'b0;
                    busy_d           = 1'b1;
                end
            end
            StSearch: begin
                // Anything other than exactly one flag means the comparator misbehaved.
                if (!$onehot({cmp_l, cmp_e, cmp_g})) begin
                    err_d    = 1'b1;
                    result_d = guess_q;
                    state_d  = StDone;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (cmp_e) begin
                    result_d = guess_q;
                    exact_d  = 1'b1;
                    state_d  = StDone;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    if (cmp_l) begin
                        next_val[k_q] = 1'b0;
                    end
                    if (k_q != '0) begin
                        guess_d        = next_val;
                        guess_d[k_dec] = 1'b1;
                        k_d            = k_dec;
                    end else begin
                        result_d = next_val;
                        state_d  = StDone;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b0;
                guess_d = '0;
                k_d     = '0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                guess_d = '0;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            k_q      <= '0;
            guess_q  <= '0;
            result_q <= '0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            exact_q  <= exact_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign exact  = exact_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Randomised and directed bench for sar_search with a combinational comparator model.
module tb_sar_search;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cmp_l, cmp_e, cmp_g;
    logic [N-1:0] guess;
    logic         busy, done, exact, err;
    logic [N-1:0] result;

    logic [N-1:0] target;
    logic         force_en;
    logic [2:0]   force_v;

    int checks = 0;
    int errors = 0;
    int last_result = 0;

    sar_search #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_l  (cmp_l),
        .cmp_e  (cmp_e),
        .cmp_g  (cmp_g),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .result (result),
        .exact  (exact),
        .err    (err)
    );

    assign cmp_l = force_en ? force_v[2] : (target < guess);
    assign cmp_e = force_en ? force_v[1] : (target == guess);
    assign cmp_g = force_en ? force_v[0] : (target > guess);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Binary search decides bits MSB-first; bits above k already match the target.
    function automatic int exp_guess(input int t, input int step);
        int k;
        k = N - 1 - step;
        return ((t >> (k + 1)) << (k + 1)) | (1 << k);
    endfunction

    function automatic int exp_len(input int t);
        for (int i = 0; i < N; i++) begin
            if (exp_guess(t, i) == t) return i + 1;
        end
        return N;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_guess"}, 32'(guess), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_exact"}, 32'(exact), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic run_search(input int t, input bit hold_start);
        int cycles;
        @(negedge clk);
        target = N'(t);
        start  = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        chk("first_exact_clear", 32'(exact), 0);
        chk("first_err_clear", 32'(err), 0);
        cycles = 0;
        while (busy === 1'b1 && cycles < N + 2) begin
            chk("guess", 32'(guess), 32'(exp_guess(t, cycles)));
            chk("result_held", 32'(result), 32'(last_result));
            chk("done_low_in_search", 32'(done), 0);
            cycles++;
            @(negedge clk);
        end
        chk("search_cycles", 32'(cycles), 32'(exp_len(t)));
        chk("done_pulse", 32'(done), 1);
        chk("busy_in_done", 32'(busy), 0);
        chk("result", 32'(result), 32'(t));
        chk("exact", 32'(exact), 32'(t != 0));
        chk("err", 32'(err), 0);
        last_result = t;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_guess", 32'(guess), 0);
        chk("idle_busy", 32'(busy), 0);
        start = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        target   = '0;
        force_en = 1'b0;
        force_v  = 3'b000;
        #3;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle_after_reset");

        run_search(5, 1'b0);
        run_search(8, 1'b0);
        run_search(15, 1'b0);
        run_search(0, 1'b0);

        // Comparator drives 000 during the second search cycle.
        @(negedge clk);
        target = 4'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_g0", 32'(guess), 8);
        @(negedge clk);
        chk("bad_g1", 32'(guess), 4);
        force_en = 1'b1;
        force_v  = 3'b000;
        @(negedge clk);
        force_en = 1'b0;
        chk("bad_done", 32'(done), 1);
        chk("bad_err", 32'(err), 1);
        chk("bad_result", 32'(result), 4);
        chk("bad_exact", 32'(exact), 0);
        last_result = 4;
        @(negedge clk);
        chk("bad_err_held_idle", 32'(err), 1);
        run_search(9, 1'b0);

        // Asynchronous reset during the third search cycle.
        @(negedge clk);
        target = 4'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_guess", 32'(guess), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        last_result = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resume_busy", 32'(busy), 0);
        chk("no_resume_guess", 32'(guess), 0);

        // Start held through search and done must not retrigger mid-search.
        run_search(11, 1'b1);
        run_search(3, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_search(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have parameter N, default 4, giving the width of the search value and the comparator operand.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new search; sampled only in IDLE.
REQ-005 SHALL have port cmp_l, input, 1 bit: external comparator flag, target < guess.
REQ-006 SHALL have port cmp_e, input, 1 bit: external comparator flag, target == guess.
REQ-007 SHALL have port cmp_g, input, 1 bit: external comparator flag, target > guess.
REQ-008 SHALL have port guess, output, N bits: registered trial value driven to the comparator B operand.
REQ-009 SHALL have port busy, output, 1 bit: high in SEARCH.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, high in DONE.
REQ-011 SHALL have port result, output, N bits: converged value, held until the next accepted start.
REQ-012 SHALL have port exact, output, 1 bit: cmp_e was observed during the last search.
REQ-013 SHALL have port err, output, 1 bit: an illegal flag combination was observed during the last search.

Function
REQ-014 SHALL implement a state machine with states IDLE, SEARCH and DONE, plus a bit index k of ceil(log2 N) or more bits.
REQ-015 In IDLE, guess SHALL be 0 and busy SHALL be 0; on start=1 the block SHALL go to SEARCH, set k=N-1, set guess=2^(N-1) and clear exact and err on the same edge.
REQ-016 SHALL treat the comparator as combinational: in each SEARCH cycle the flags reflect the current guess and are sampled at the end of that cycle.
REQ-017 In SEARCH, a flag set other than exactly one of cmp_l, cmp_e, cmp_g high (000, 011, 101, 110, 111) SHALL set err=1 and result=guess, then go to DONE.
REQ-018 In SEARCH with cmp_e=1, the block SHALL set result=guess and exact=1, then go to DONE (early termination).
REQ-019 In SEARCH with cmp_l=1, the block SHALL compute next = guess with bit k cleared; with cmp_g=1, next = guess.
REQ-020 If k>0, guess SHALL become next with bit k-1 set, k SHALL decrement, and the block SHALL stay in SEARCH.
REQ-021 If k=0, result SHALL become next, exact SHALL stay 0, and the block SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1 and busy=0, SHALL return to IDLE unconditionally, and guess SHALL return to 0 on entry to IDLE.
REQ-023 Maximum latency SHALL be N SEARCH cycles; done SHALL be high in the cycle after the final SEARCH cycle.
REQ-024 start in SEARCH or DONE SHALL be ignored, with no queuing.
REQ-025 result, exact and err SHALL change only on exit from SEARCH or on reset; clearing exact and err per REQ-015 is the sole exception.
REQ-026 Target value 0 SHALL converge to result=0 with exact=0, because equality is never presented; this is legal, not an error.

Reset
REQ-027 Assertion of rst_n=0 SHALL immediately force state=IDLE, k=0, guess=0, busy=0, done=0, result=0, exact=0 and err=0, including mid-search.
REQ-028 After rst_n deasserts, the block SHALL wait for a new start; no interrupted search resumes.

Verification
REQ-029 The bench SHALL model the comparator combinationally from target and guess, and SHALL cover the following scenarios with N=4:
- Target 5, start pulse -> guess sequence 8, 4, 6, 5; done in the 5th cycle after the start edge; result=5, exact=1, err=0.
- Target 8 -> one SEARCH cycle (guess 8, cmp_e); done next cycle; result=8, exact=1.
- Target 15 -> guesses 8, 12, 14, 15; result=15, exact=1. Target 0 -> guesses 8, 4, 2, 1; result=0, exact=0, err=0.
- Flags forced to 000 at the second SEARCH cycle -> err=1, result=4, done pulses; the next start clears err.
- rst_n low during the 3rd SEARCH cycle -> all outputs 0 asynchronously; start held high in SEARCH and DONE has no effect; a fresh start then completes normally.
